inst_fetch: RTL

//  Instruction fetch stage feeding the processor core: holds a small loadable

---
 rtl/inst_fetch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage. Holds a small loadable instruction store and the
//   program counter. A prescaler paces issue slots, and one instruction is
//   presented at a time on a valid/ready handshake.
//
// Ports
//   i_clk          system clock, all state on rising edge
//   i_reset_n      asynchronous active-low reset
//   i_run          1 = issue instructions, 0 = halt after the current handshake
//   i_restart      pulse, clears the PC (IDLE only)
//   i_load_en      store write strobe (IDLE only)
//   i_load_addr    store write address
//   i_load_data    store write data
//   o_instruction  presented instruction, stable while o_inst_valid=1
//   o_inst_valid   instruction valid
//   i_inst_ready   consumer accepts the instruction this cycle
//   o_pc           address of the instruction presented / next to fetch
//   o_wrap         1-cycle pulse after the PC wraps DEPTH-1 -> 0
//
// States
//   state       | meaning
//   S_IDLE      | halted; store load and PC restart accepted here
//   S_WAIT_TICK | prescaler counting toward the next issue slot
//   S_PRESENT   | instruction on the output, waiting for the handshake
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int TICK_DIV = 30000000
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_run,
  input  logic          i_restart,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [DW-1:0] i_load_data,
  output logic [DW-1:0] o_instruction,
  output logic          o_inst_valid,
  input  logic          i_inst_ready,
  output logic [AW-1:0] o_pc,
  output logic          o_wrap
);

  // A divide-by-one still needs a 1-bit counter; the compare value is then 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TICK = 2'd1,
    S_PRESENT   = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [DW-1:0] r_instr, w_instr_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_wrap, w_wrap_nxt;
  logic          w_mem_we;
  logic          w_tick;

  // Store contents survive reset so a loaded program can be rerun.
  logic [DW-1:0] r_mem [DEPTH];

  assign w_tick = (r_presc == TICK_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_presc_nxt = r_presc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_mem_we    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_mem_we = i_load_en;
        if (i_restart) w_pc_nxt = '0;
        if (i_run) begin
          w_state_nxt = S_WAIT_TICK;
          w_presc_nxt = '0;
        end
      end

      S_WAIT_TICK: begin
        if (!i_run) begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end else if (w_tick) begin
          w_instr_nxt = r_mem[r_pc];
          w_valid_nxt = 1'b1;
          w_presc_nxt = '0;
          w_state_nxt = S_PRESENT;
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end

      S_PRESENT: begin
        // Prescaler stays frozen here; run only matters once the handshake
        // completes, so a presented instruction is never retracted.
        if (i_inst_ready) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = r_pc + 1'b1;
          w_presc_nxt = '0;
          w_wrap_nxt  = (r_pc == PC_LAST);
          w_state_nxt = i_run ? S_WAIT_TICK : S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_presc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_presc <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_presc <= w_presc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[i_load_addr] <= i_load_data;
  end

  assign o_instruction = r_instr;
  assign o_inst_valid  = r_valid;
  assign o_pc          = r_pc;
  assign o_wrap        = r_wrap;

endmodule
